// File: rtl/led_pkg.sv
// Shared state encodings and elaboration helpers for the LED blink arbiter.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: one-cycle tick every DIV clocks, restartable by clr.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (clog2(DIV) == 0) ? 1 : clog2(DIV);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == TOP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TOP);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED among NUM_REQ burst requesters.
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned HP_W      = 10,
    parameter int unsigned GAP_TICKS = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [4*NUM_REQ-1:0]    req_blinks,
    input  logic [HP_W*NUM_REQ-1:0] req_half,
    input  logic                    abort,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    busy,
    output logic                    led
);

    localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
    localparam int unsigned IDX_W = clog2(NUM_REQ);
    localparam logic [HP_W-1:0] GAP_M1 = HP_W'(GAP_TICKS - 1);

    if (64'(GAP_TICKS) >= (64'd1 << HP_W) || GAP_TICKS == 0) begin : g_gap_chk
        $error("GAP_TICKS must be in 1 .. 2**HP_W-1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_chk
        $error("NUM_REQ must be in 2 .. 8");
    end
    if (DIV == 0) begin : g_div_chk
        $error("CLK_FREQ must be at least TICK_HZ");
    end

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    logic [3:0]      bl_arr [NUM_REQ];
    logic [HP_W-1:0] hp_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign bl_arr[g] = req_blinks[4*g +: 4];
        assign hp_arr[g] = req_half[HP_W*g +: HP_W];
    end

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt, win, win_nxt, sel;
    logic [3:0]         rem, rem_nxt;
    logic [HP_W-1:0]    hp_m1, hp_m1_nxt, phase, phase_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
    logic               busy_nxt, led_nxt, found, clr, tick, phase_end;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // First active request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[rr_idx(ptr, k)]) begin
                found = 1'b1;
                sel   = rr_idx(ptr, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            win   <= '0;
            rem   <= '0;
            hp_m1 <= '0;
            phase <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            led   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            rem   <= rem_nxt;
            hp_m1 <= hp_m1_nxt;
            phase <= phase_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
            led   <= led_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        rem_nxt   = rem;
        hp_m1_nxt = hp_m1;
        phase_nxt = phase;
        gnt_nxt   = '0;
        done_nxt  = '0;
        busy_nxt  = busy;
        led_nxt   = led;
        clr       = 1'b0;
        phase_end = tick && (phase == ((state == ST_GAP) ? GAP_M1 : hp_m1));

        if (state == ST_IDLE) begin
            if (found) begin
                // Zero-valued fields behave as 1 blink / 1 tick.
                win_nxt   = sel;
                ptr_nxt   = rr_idx(sel, 1);
                rem_nxt   = (bl_arr[sel] == 4'd0) ? 4'd1 : bl_arr[sel];
                hp_m1_nxt = (hp_arr[sel] == '0) ? '0 : hp_arr[sel] - HP_W'(1);
                phase_nxt = '0;
                gnt_nxt   = NUM_REQ'(1) << sel;
                busy_nxt  = 1'b1;
                led_nxt   = 1'b1;
                clr       = 1'b1;
                state_nxt = ST_ON;
            end
        end else if (abort) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            led_nxt   = 1'b0;
            phase_nxt = '0;
            rem_nxt   = '0;
        end else if (tick) begin
            if (!phase_end) begin
                phase_nxt = phase + HP_W'(1);
            end else begin
                phase_nxt = '0;
                case (state)
                    ST_ON: begin
                        led_nxt   = 1'b0;
                        state_nxt = ST_OFF;
                    end
                    ST_OFF: begin
                        rem_nxt = rem - 4'd1;
                        if (rem == 4'd1) begin
                            state_nxt = ST_GAP;
                        end else begin
                            led_nxt   = 1'b1;
                            state_nxt = ST_ON;
                        end
                    end
                    ST_GAP: begin
                        done_nxt  = NUM_REQ'(1) << win;
                        busy_nxt  = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

endmodule
